// File: rtl/refund_coin_dispenser.sv
// refund_coin_dispenser: pays a refund balance (units of 0.1 yuan) out as a
// timed pulse train on three coin ejectors (5 / 1 / 0.5 yuan), greedy
// largest-coin-first, one coin per SELECT decision.
//
// Optional feature macro: INVENTORY_EN
//   Undefined (default): unlimited stock, short tied low, restock unused.
//   Defined: 8-bit stock counter per denomination, empty denominations are
//   skipped, and a payout that cannot finish reports short=1.
//
// Request protocol: refund_req is a single-cycle request with no ready
// handshake. It is accepted only when busy=0 (IDLE), where refund_amount is
// sampled on the same edge. A refund_req seen in any other state is discarded
// and answered by a one-cycle dropped strobe; the running payout continues.
//
// Debug: state_dbg exposes the FSM state register
//   (0=IDLE, 1=SELECT, 2=PULSE, 3=GAP, 4=DONE).

module refund_coin_dispenser #(
    parameter int PULSE_CYCLES = 2,
    parameter int GAP_CYCLES   = 2,
    parameter int INIT_STOCK5  = 20,
    parameter int INIT_STOCK1  = 20,
    parameter int INIT_STOCK0  = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       refund_req,
    input  logic [9:0] refund_amount,
    input  logic       restock,
    output logic       coin5,
    output logic       coin1,
    output logic       coin0,
    output logic       busy,
    output logic       done,
    output logic [9:0] residue,
    output logic       short,
    output logic       dropped,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SELECT = 3'd1,
        S_PULSE  = 3'd2,
        S_GAP    = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    // Amounts above this are clamped on capture.
    localparam logic [9:0] MAX_AMOUNT = 10'd999;

    // Coin values in units of 0.1 yuan.
    localparam logic [9:0] VAL5 = 10'd50;
    localparam logic [9:0] VAL1 = 10'd10;
    localparam logic [9:0] VAL0 = 10'd5;

    // Terminal counts of the shared pulse/gap timer.
    localparam logic [15:0] PULSE_LAST = 16'(PULSE_CYCLES - 1);
    localparam logic [15:0] GAP_LAST   = 16'(GAP_CYCLES - 1);

    state_t      state;
    logic [9:0]  remainder;
    logic [15:0] cnt;

    // Availability of each denomination (always available without inventory).
    logic have5;
    logic have1;
    logic have0;

    // Coin chosen by the current SELECT cycle (at most one is set).
    logic pick5;
    logic pick1;
    logic pick0;

`ifdef INVENTORY_EN
    logic [7:0] stock5;
    logic [7:0] stock1;
    logic [7:0] stock0;
    logic       short_q;

    // Stock is visible to SELECT only through the have* flags.
    always_comb begin
        have5 = (stock5 != 8'd0);
        have1 = (stock1 != 8'd0);
        have0 = (stock0 != 8'd0);
    end

    // Stock counters: reload on reset or an idle restock, count down on the
    // SELECT that dispatches a coin of that denomination.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stock5 <= 8'(INIT_STOCK5);
            stock1 <= 8'(INIT_STOCK1);
            stock0 <= 8'(INIT_STOCK0);
        end else if (state == S_IDLE && restock) begin
            stock5 <= 8'(INIT_STOCK5);
            stock1 <= 8'(INIT_STOCK1);
            stock0 <= 8'(INIT_STOCK0);
        end else if (state == S_SELECT) begin
            if (pick5) stock5 <= stock5 - 8'd1;
            if (pick1) stock1 <= stock1 - 8'd1;
            if (pick0) stock0 <= stock0 - 8'd1;
        end
    end

    // Short flag: cleared on accept, set when SELECT finds coins still owed
    // but nothing left to pay them with.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            short_q <= 1'b0;
        end else if (state == S_IDLE && refund_req) begin
            short_q <= 1'b0;
        end else if (state == S_SELECT && !pick5 && !pick1 && !pick0 &&
                     remainder >= VAL0) begin
            short_q <= 1'b1;
        end
    end

    assign short = short_q;
`else
    // Unlimited stock: every denomination is always usable.
    always_comb begin
        have5 = 1'b1;
        have1 = 1'b1;
        have0 = 1'b1;
    end

    logic unused_restock;
    assign unused_restock = restock;
    assign short          = 1'b0;
`endif

    // Greedy choice: largest denomination that fits and is in stock.
    always_comb begin
        pick5 = 1'b0;
        pick1 = 1'b0;
        pick0 = 1'b0;
        if (remainder >= VAL5 && have5) begin
            pick5 = 1'b1;
        end else if (remainder >= VAL1 && have1) begin
            pick1 = 1'b1;
        end else if (remainder >= VAL0 && have0) begin
            pick0 = 1'b1;
        end
    end

    // Payout FSM with registered coin, busy, done, residue and dropped outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            remainder <= 10'd0;
            cnt       <= 16'd0;
            coin5     <= 1'b0;
            coin1     <= 1'b0;
            coin0     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            residue   <= 10'd0;
            dropped   <= 1'b0;
        end else begin
            done    <= 1'b0;
            dropped <= (state != S_IDLE) && refund_req;
            case (state)
                S_IDLE: begin
                    if (refund_req) begin
                        remainder <= (refund_amount > MAX_AMOUNT) ? MAX_AMOUNT
                                                                  : refund_amount;
                        residue   <= 10'd0;
                        busy      <= 1'b1;
                        state     <= S_SELECT;
                    end
                end
                S_SELECT: begin
                    cnt <= 16'd0;
                    if (pick5) begin
                        remainder <= remainder - VAL5;
                        coin5     <= 1'b1;
                        state     <= S_PULSE;
                    end else if (pick1) begin
                        remainder <= remainder - VAL1;
                        coin1     <= 1'b1;
                        state     <= S_PULSE;
                    end else if (pick0) begin
                        remainder <= remainder - VAL0;
                        coin0     <= 1'b1;
                        state     <= S_PULSE;
                    end else begin
                        done    <= 1'b1;
                        residue <= remainder;
                        state   <= S_DONE;
                    end
                end
                S_PULSE: begin
                    if (cnt == PULSE_LAST) begin
                        coin5 <= 1'b0;
                        coin1 <= 1'b0;
                        coin0 <= 1'b0;
                        cnt   <= 16'd0;
                        state <= S_GAP;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt   <= 16'd0;
                        state <= S_SELECT;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    coin5 <= 1'b0;
                    coin1 <= 1'b0;
                    coin0 <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign state_dbg = state;

endmodule
